branch_predictor: RTL and testbench

- Next-PC predictor for the 16-bit, word-addressed pipelined TSC CPU, implemented as a direct-mapped BTB with 2-bit saturating counters.
- Looks up the IF-stage PC each cycle and supplies the predicted next PC.
- Receives branch resolutions from EX and jump resolutions from ID.
- Produces the BranchMisprediction / JumpMisprediction inputs of the CPU control unit, plus the corrected PC.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/btb_array.sv | 69 ++++++
 rtl/branch_predictor.sv | 99 +++++++++
 tb/tb_branch_predictor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types, counter encodings and helpers for the TSC next-PC branch predictor.
package bp_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int DEF_INDEX_BITS = 4;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Tags are stored zero-extended to a full word so the entry type
    // stays independent of the INDEX_BITS chosen by the instantiating block.
    typedef struct packed {
        logic                 valid;
        logic [WORD_SIZE-1:0] tag;
        logic [WORD_SIZE-1:0] target;
        logic                 is_jump;
        logic [1:0]           ctr;
    } btb_entry_t;

    localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0,
                                           is_jump: 1'b0, ctr: WNT};

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == ST) ? ST : ctr + 2'd1;
        else
            return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: one combinational read port, a branch and a jump
// update request merged into one write per index (branch wins on a shared index).
module btb_array
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output btb_entry_t            rd_entry,
    input  logic                  br_we,
    input  logic [INDEX_BITS-1:0] br_idx,
    input  logic [WORD_SIZE-1:0]  br_tag,
    input  logic                  br_taken,
    input  logic [WORD_SIZE-1:0]  br_target,
    input  logic                  jp_we,
    input  logic [INDEX_BITS-1:0] jp_idx,
    input  logic [WORD_SIZE-1:0]  jp_tag,
    input  logic [WORD_SIZE-1:0]  jp_target
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    btb_entry_t mem [ENTRIES];
    btb_entry_t br_old;
    btb_entry_t br_new;
    btb_entry_t jp_new;
    logic       jp_write;

    assign rd_entry = mem[rd_idx];
    assign br_old   = mem[br_idx];
    assign jp_write = jp_we && !(br_we && (br_idx == jp_idx));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        br_new = RESET_ENTRY;
        if (br_old.valid && (br_old.tag == br_tag)) begin
            br_new         = br_old;
            br_new.ctr     = sat_update(br_old.ctr, br_taken);
            br_new.target  = br_target;
            br_new.is_jump = 1'b0;
        end else begin
            br_new = '{valid: 1'b1, tag: br_tag, target: br_target,
                       is_jump: 1'b0, ctr: (br_taken ? WT : WNT)};
        end
    end

    always_comb begin
        jp_new = '{valid: 1'b1, tag: jp_tag, target: jp_target, is_jump: 1'b1, ctr: ST};
    end

    // NOTE: the storage is reset because stale valid bits would produce false hits;
    // a reset edge also drops any update requested in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++)
                mem[i] <= RESET_ENTRY;
        end else begin
            // NOTE: state is written with non-blocking assignments so readers in the
            // same edge see the old entry, which gives the no-bypass read behaviour.
            if (jp_write)
                mem[jp_idx] <= jp_new;
            if (br_we)
                mem[br_idx] <= br_new;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor for the TSC pipeline: BTB lookup, branch/jump misprediction
// detection and corrected PC. Define BP_STATS_EN to add saturating event counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 pred_taken,
    input  logic                 br_valid,
    input  logic [WORD_SIZE-1:0] br_pc,
    input  logic                 br_taken,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic [WORD_SIZE-1:0] br_fetched_next,
    input  logic                 jp_valid,
    input  logic [WORD_SIZE-1:0] jp_pc,
    input  logic [WORD_SIZE-1:0] jp_target,
    input  logic [WORD_SIZE-1:0] jp_fetched_next,
    output logic                 BranchMisprediction,
    output logic                 JumpMisprediction,
    output logic [WORD_SIZE-1:0] correct_pc
`ifdef BP_STATS_EN
    ,
    output logic [15:0]          num_branch,
    output logic [15:0]          num_br_mispred,
    output logic [15:0]          num_jp_mispred
`endif
);

    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    btb_entry_t           rd_entry;
    logic [WORD_SIZE-1:0] if_tag;
    logic [WORD_SIZE-1:0] br_tag;
    logic [WORD_SIZE-1:0] jp_tag;
    logic [WORD_SIZE-1:0] actual_br;
    logic                 hit;

    assign if_tag = {{INDEX_BITS{1'b0}}, if_pc[INDEX_BITS +: TAG_BITS]};
    assign br_tag = {{INDEX_BITS{1'b0}}, br_pc[INDEX_BITS +: TAG_BITS]};
    assign jp_tag = {{INDEX_BITS{1'b0}}, jp_pc[INDEX_BITS +: TAG_BITS]};

    assign hit        = rd_entry.valid && (rd_entry.tag == if_tag);
    assign pred_taken = reset_n && hit && (rd_entry.is_jump || (rd_entry.ctr >= WT));
    assign pred_pc    = pred_taken ? rd_entry.target : if_pc + WORD_SIZE'(1);

    assign actual_br           = br_taken ? br_target : br_pc + WORD_SIZE'(1);
    assign BranchMisprediction = reset_n && br_valid && (actual_br != br_fetched_next);
    // A mispredicted older branch flushes the jump, so its verdict is suppressed.
    assign JumpMisprediction   = reset_n && jp_valid && (jp_target != jp_fetched_next)
                                 && !BranchMisprediction;

    always_comb begin
        correct_pc = pred_pc;
        if (BranchMisprediction)
            correct_pc = actual_br;
        else if (JumpMisprediction)
            correct_pc = jp_target;
    end

    btb_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_btb (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_idx    (if_pc[INDEX_BITS-1:0]),
        .rd_entry  (rd_entry),
        .br_we     (br_valid),
        .br_idx    (br_pc[INDEX_BITS-1:0]),
        .br_tag    (br_tag),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jp_we     (jp_valid && !BranchMisprediction),
        .jp_idx    (jp_pc[INDEX_BITS-1:0]),
        .jp_tag    (jp_tag),
        .jp_target (jp_target)
    );

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_branch     <= '0;
            num_br_mispred <= '0;
            num_jp_mispred <= '0;
        end else begin
            if (br_valid && (num_branch != 16'hFFFF))
                num_branch <= num_branch + 16'd1;
            if (BranchMisprediction && (num_br_mispred != 16'hFFFF))
                num_br_mispred <= num_br_mispred + 16'd1;
            if (JumpMisprediction && (num_jp_mispred != 16'hFFFF))
                num_jp_mispred <= num_jp_mispred + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor; stats counters are checked when BP_STATS_EN is defined.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] if_pc;
    logic [15:0] pred_pc;
    logic        pred_taken;
    logic        br_valid;
    logic [15:0] br_pc;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] br_fetched_next;
    logic        jp_valid;
    logic [15:0] jp_pc;
    logic [15:0] jp_target;
    logic [15:0] jp_fetched_next;
    logic        BranchMisprediction;
    logic        JumpMisprediction;
    logic [15:0] correct_pc;
`ifdef BP_STATS_EN
    logic [15:0] num_branch;
    logic [15:0] num_br_mispred;
    logic [15:0] num_jp_mispred;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .if_pc               (if_pc),
        .pred_pc             (pred_pc),
        .pred_taken          (pred_taken),
        .br_valid            (br_valid),
        .br_pc               (br_pc),
        .br_taken            (br_taken),
        .br_target           (br_target),
        .br_fetched_next     (br_fetched_next),
        .jp_valid            (jp_valid),
        .jp_pc               (jp_pc),
        .jp_target           (jp_target),
        .jp_fetched_next     (jp_fetched_next),
        .BranchMisprediction (BranchMisprediction),
        .JumpMisprediction   (JumpMisprediction),
        .correct_pc          (correct_pc)
`ifdef BP_STATS_EN
        ,
        .num_branch          (num_branch),
        .num_br_mispred      (num_br_mispred),
        .num_jp_mispred      (num_jp_mispred)
`endif
    );

    typedef struct {
        logic        r;
        logic [15:0] ifpc;
        logic        bv;
        logic [15:0] bpc;
        logic        bt;
        logic [15:0] btg;
        logic [15:0] bfn;
        logic        jv;
        logic [15:0] jpc;
        logic [15:0] jtg;
        logic [15:0] jfn;
        logic [15:0] epred;
        logic        etk;
        logic        ebm;
        logic        ejm;
        logic [15:0] ecor;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, compare 1 time unit later; the next rising edge commits.
    task automatic apply(input vec_t v, input int n);
        @(negedge clk);
        reset_n         = v.r;
        if_pc           = v.ifpc;
        br_valid        = v.bv;
        br_pc           = v.bpc;
        br_taken        = v.bt;
        br_target       = v.btg;
        br_fetched_next = v.bfn;
        jp_valid        = v.jv;
        jp_pc           = v.jpc;
        jp_target       = v.jtg;
        jp_fetched_next = v.jfn;
        #1;
        check($sformatf("v%0d pred_pc", n), pred_pc, v.epred);
        check($sformatf("v%0d pred_taken", n), {15'd0, pred_taken}, {15'd0, v.etk});
        check($sformatf("v%0d BranchMisprediction", n), {15'd0, BranchMisprediction}, {15'd0, v.ebm});
        check($sformatf("v%0d JumpMisprediction", n), {15'd0, JumpMisprediction}, {15'd0, v.ejm});
        check($sformatf("v%0d correct_pc", n), correct_pc, v.ecor);
    endtask

    function automatic void add(
        input logic r, input logic [15:0] ifpc,
        input logic bv, input logic [15:0] bpc, input logic bt, input logic [15:0] btg, input logic [15:0] bfn,
        input logic jv, input logic [15:0] jpc, input logic [15:0] jtg, input logic [15:0] jfn,
        input logic [15:0] epred, input logic etk, input logic ebm, input logic ejm, input logic [15:0] ecor);
        vecs.push_back('{r, ifpc, bv, bpc, bt, btg, bfn, jv, jpc, jtg, jfn, epred, etk, ebm, ejm, ecor});
    endfunction

    initial begin
        //  r  if_pc     bv bpc      bt btg      bfn       jv jpc      jtg      jfn       pred     tk bm jm correct
        add(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0, 16'h0011); // v0 reset
        add(0, 16'hFFFF, 1, 16'h0010, 1, 16'h0020, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000); // v1 reset masks mispredict, drops update
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0, 16'h0011); // v2
        add(1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000); // v3 wrap
        add(1, 16'h0010, 1, 16'h0010, 1, 16'h0020, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 1, 0, 16'h0020); // v4 no bypass
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0, 0, 16'h0020); // v5 ctr=2
        add(1, 16'h0010, 1, 16'h0010, 0, 16'h0020, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 1, 0, 16'h0011); // v6 ->1
        add(1, 16'h0010, 1, 16'h0010, 0, 16'h0020, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0, 16'h0011); // v7 ->0
        add(1, 16'h0010, 1, 16'h0010, 0, 16'h0020, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0, 16'h0011); // v8 stays 0
        add(1, 16'h0010, 1, 16'h0010, 1, 16'h0020, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 1, 0, 16'h0020); // v9 ->1
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0, 16'h0011); // v10 floor held
        add(1, 16'h0010, 1, 16'h0010, 1, 16'h0020, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 1, 0, 16'h0020); // v11 ->2
        add(1, 16'h0010, 1, 16'h0010, 1, 16'h0020, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0, 0, 16'h0020); // v12 ->3
        add(1, 16'h0010, 1, 16'h0010, 1, 16'h0020, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0, 0, 16'h0020); // v13 stays 3
        add(1, 16'h0010, 1, 16'h0010, 0, 16'h0020, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 1, 0, 16'h0011); // v14 ->2
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0, 0, 16'h0020); // v15 ceiling held
        add(1, 16'h0030, 1, 16'h0030, 1, 16'h0040, 16'h0031, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0031, 0, 1, 0, 16'h0040); // v16 alias
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0, 16'h0011); // v17
        add(1, 16'h0030, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 1, 0, 0, 16'h0040); // v18
        add(1, 16'h0025, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0025, 16'h0050, 16'h0026, 16'h0026, 0, 0, 1, 16'h0050); // v19 jump
        add(1, 16'h0025, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0050, 1, 0, 0, 16'h0050); // v20
        add(1, 16'h0007, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0025, 16'h0050, 16'h0050, 16'h0008, 0, 0, 0, 16'h0008); // v21
        add(1, 16'h0015, 1, 16'h0010, 1, 16'h0020, 16'h0011, 1, 16'h0015, 16'h0050, 16'h0016, 16'h0016, 0, 1, 0, 16'h0020); // v22 both
        add(1, 16'h0015, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0016, 0, 0, 0, 16'h0016); // v23 idx5 empty
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0, 0, 16'h0020); // v24
        add(1, 16'h0040, 1, 16'h0010, 1, 16'h0020, 16'h0020, 1, 16'h0040, 16'h0070, 16'h0070, 16'h0041, 0, 0, 0, 16'h0041); // v25 same idx
        add(1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0041, 0, 0, 0, 16'h0041); // v26 branch won
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0, 0, 16'h0020); // v27
        add(1, 16'h0033, 1, 16'h0010, 1, 16'h0020, 16'h0020, 1, 16'h0033, 16'h0099, 16'h0034, 16'h0034, 0, 0, 1, 16'h0099); // v28
        add(1, 16'h0033, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0099, 1, 0, 0, 16'h0099); // v29
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0010, 16'h0077, 16'h0020, 16'h0020, 1, 0, 1, 16'h0077); // v30
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0077, 1, 0, 0, 16'h0077); // v31
        add(0, 16'h0033, 1, 16'h0033, 1, 16'h0055, 16'h0034, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0034, 0, 0, 0, 16'h0034); // v32 mid-run reset
        add(1, 16'h0033, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0034, 0, 0, 0, 16'h0034); // v33
        add(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0, 16'h0011); // v34

        for (int i = 0; i < 32; i++)
            apply(vecs[i], i);

        @(negedge clk);
        #1;
`ifdef BP_STATS_EN
        check("num_branch", num_branch, 16'd13);
        check("num_br_mispred", num_br_mispred, 16'd7);
        check("num_jp_mispred", num_jp_mispred, 16'd3);
`endif

        for (int i = 32; i < vecs.size(); i++)
            apply(vecs[i], i);

        // After the mid-run reset every index must miss.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] pc;
            pc = 16'h0010 + 16'(i);
            @(negedge clk);
            if_pc = pc;
            #1;
            check($sformatf("sweep %h pred_pc", pc), pred_pc, pc + 16'd1);
            check($sformatf("sweep %h pred_taken", pc), {15'd0, pred_taken}, 16'd0);
        end
        if_pc = 16'h0033;
        #1;
        check("sweep 0033 pred_pc", pred_pc, 16'h0034);
`ifdef BP_STATS_EN
        check("num_branch after reset", num_branch, 16'd0);
        check("num_br_mispred after reset", num_br_mispred, 16'd0);
        check("num_jp_mispred after reset", num_jp_mispred, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
